// File: rtl/reg8_share_arbiter.sv
// Round-robin write arbiter sharing one DATA_W-bit register between two requesters.
// Each write takes IDLE -> LOAD -> ACK; the winner's data is captured at the LOAD edge.
module reg8_share_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] d0,
  input  logic              req1,
  input  logic [DATA_W-1:0] d1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] q,
  output logic              owner,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   prio;
  logic   winner;

  // prio names the requester that wins a tie; it flips away from whoever was just served
  always_comb begin
    state_nxt = state;
    winner    = owner;
    case (state)
      IDLE: begin
        if (req0 && req1) winner = prio;
        else              winner = req1;
        if (req0 || req1) state_nxt = LOAD;
      end
      LOAD:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      q      <= '0;
      wr_cnt <= '0;
      prio   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req0 || req1))
        owner <= winner;
      if (state == LOAD)
        q <= owner ? d1 : d0;
      if (state == ACK) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        prio   <= ~owner;
      end
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == ACK) && !owner;
  assign ack1 = (state == ACK) && owner;

endmodule

// File: doc/reg8_share_arbiter.md
Name: reg8_share_arbiter

Overview:
Round-robin write arbiter that shares one 8-bit D-flip-flop register between two requesters. Each requester posts data with a req/ack handshake. The block selects a winner, loads its data into the shared register, acknowledges it, and counts completed writes. It sits in front of the 8-bit register datapath and is the only writer of that register.

Parameters:
DATA_W, 8, width of the shared register and of each requester data bus
CNT_W, 4, width of the completed-write counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  write request, requester 0; held high until ack0
d0  input  DATA_W  write data, requester 0; held stable while req0 is high
req1  input  1  write request, requester 1; held high until ack1
d1  input  DATA_W  write data, requester 1; held stable while req1 is high
ack0  output  1  one-cycle write-done pulse to requester 0
ack1  output  1  one-cycle write-done pulse to requester 1
q  output  DATA_W  current contents of the shared register
owner  output  1  index of the requester currently being served, or last served
busy  output  1  high while a transaction is in progress (LOAD or ACK)
wr_cnt  output  CNT_W  number of completed writes, modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values, taking effect at the first clock edge with reset=1:
  - q=0, ack0=ack1=0, owner=0, busy=0, wr_cnt=0
  - state=IDLE
  - priority pointer set to favour requester 0
- Reset has priority over every other event, including mid-transaction. A transaction interrupted by reset is abandoned: no ack is issued and q is cleared.
- FSM: Moore machine with 3 states (IDLE, LOAD, ACK). All outputs come from registers or from the state only. No combinational path from req to ack.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both reqs: the requester favoured by the priority pointer wins.
  - On winning, owner <= winner and next state is LOAD. busy=0 in IDLE.
- LOAD:
  - busy=1.
  - At the end edge, q <= d[owner] and next state is ACK.
  - Data is sampled only at this edge.
  - If the owner drops req during LOAD (protocol violation), the write still completes with the sampled data.
- ACK:
  - busy=1 and ack[owner]=1 for exactly this cycle; the other ack stays 0.
  - q already shows the new value.
  - At the end edge: wr_cnt <= wr_cnt+1, wrapping from 2^CNT_W-1 to 0; the priority pointer is set to favour the non-owner; next state is IDLE.
- Latency: req sampled high in IDLE at cycle n. LOAD is cycle n+1. ACK pulse and new q appear in cycle n+2.
- Throughput: at most one write per 3 cycles.
- A req still high in the IDLE cycle after its ack counts as a new request. With both reqs held, service strictly alternates.
- Requests arriving during LOAD or ACK wait; they are evaluated on the next IDLE cycle.
- q changes only at the LOAD→ACK edge or on reset. owner changes only on leaving IDLE or on reset.

Test Plan:
1. Reset: hold reset 2 cycles with req0=req1=1 -> q=00, ack0=ack1=0, busy=0, owner=0, wr_cnt=0 throughout.
2. Single write: req0=1, d0=A5 sampled in IDLE at cycle n -> busy=1 in n+1 and n+2; ack0=1 only in n+2 with q=A5; ack1 stays 0; wr_cnt=1 after n+2.
3. Simultaneous requests: from reset, req0=req1=1, d0=11, d1=22, each dropped the cycle after its own ack -> ack0 first with q=11, then 3 cycles later ack1 with q=22, wr_cnt=2.
4. Fairness: req0 and req1 held high for 12 cycles after reset -> ack order 0,1,0,1 with owner alternating, wr_cnt=4.
5. Counter wrap: 16 back-to-back req1 writes with d1=00..0F -> final q=0F, wr_cnt wraps to 0 after the 16th ack.
6. Reset mid-transaction: req1=1, d1=3C, reset asserted for one cycle during LOAD -> no ack1 pulse, q=00, state IDLE. With req1 still held, the transaction reruns and ack1 arrives with q=3C 3 cycles after reset deasserts.
